// File: rtl/triangle_pkg.sv
// rtl/triangle_pkg.sv - state and direction encodings shared by the triangle generator and analyzer
package triangle_pkg;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      ACQUIRE    = 2'd1,
      TRACK_UP   = 2'd2,
      TRACK_DOWN = 2'd3
   } state_t;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

   function automatic logic is_tracking(input state_t s);
      return (s == TRACK_UP) || (s == TRACK_DOWN);
   endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - up counter that sticks at all-ones; clear wins over increment
module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + ONE;
      end
   end

endmodule

// File: rtl/triangle_analyzer.sv
// rtl/triangle_analyzer.sv - locks onto a full-range triangle waveform, flags peaks/troughs/illegal steps
module triangle_analyzer
   import triangle_pkg::*;
#(
   parameter int N     = 8,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ena,
   input  logic [N-1:0]     sample,
   output logic             direction,
   output logic             locked,
   output logic             peak_pulse,
   output logic             trough_pulse,
   output logic             step_error,
   output logic [CNT_W-1:0] err_count,
   output logic [CNT_W-1:0] period,
   output logic             period_valid
);

   localparam logic [N-1:0]     ONE     = {{(N-1){1'b0}}, 1'b1};
   localparam logic [N-1:0]     TOP     = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t           state, state_next;
   logic [N-1:0]     prev, prev_inc, prev_dec;
   logic             dir_next, peak_next, trough_next, error_next;
   logic             seen_trough;
   logic [CNT_W-1:0] period_cnt;

   assign prev_inc = prev + ONE;
   assign prev_dec = prev - ONE;

   always_comb begin
      state_next  = state;
      dir_next    = direction;
      peak_next   = 1'b0;
      trough_next = 1'b0;
      error_next  = 1'b0;
      if (ena) begin
         case (state)
            IDLE: state_next = ACQUIRE;
            ACQUIRE: begin
               if (sample == prev_inc) begin
                  state_next = TRACK_UP;
                  dir_next   = DIR_UP;
               end else if (sample == prev_dec) begin
                  state_next = TRACK_DOWN;
                  dir_next   = DIR_DOWN;
               end else begin
                  error_next = 1'b1;
               end
            end
            TRACK_UP: begin
               // at the top the only legal move is the turn back down
               if (prev == TOP) begin
                  if (sample == prev_dec) begin
                     peak_next  = 1'b1;
                     state_next = TRACK_DOWN;
                     dir_next   = DIR_DOWN;
                  end else begin
                     error_next = 1'b1;
                  end
               end else if (sample != prev_inc) begin
                  error_next = 1'b1;
               end
            end
            TRACK_DOWN: begin
               if (prev == '0) begin
                  if (sample == prev_inc) begin
                     trough_next = 1'b1;
                     state_next  = TRACK_UP;
                     dir_next    = DIR_UP;
                  end else begin
                     error_next = 1'b1;
                  end
               end else if (sample != prev_dec) begin
                  error_next = 1'b1;
               end
            end
            default: state_next = IDLE;
         endcase
         if (error_next) state_next = ACQUIRE;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         prev         <= '0;
         direction    <= DIR_UP;
         locked       <= 1'b0;
         peak_pulse   <= 1'b0;
         trough_pulse <= 1'b0;
         step_error   <= 1'b0;
         period       <= '0;
         period_valid <= 1'b0;
         seen_trough  <= 1'b0;
      end else begin
         state        <= state_next;
         direction    <= dir_next;
         locked       <= is_tracking(state_next);
         peak_pulse   <= peak_next;
         trough_pulse <= trough_next;
         step_error   <= error_next;
         period_valid <= trough_next && seen_trough;
         if (ena) prev <= sample;
         // the trough sample itself closes the period, hence the +1
         if (trough_next) begin
            period      <= (period_cnt == CNT_MAX) ? CNT_MAX : period_cnt + CNT_ONE;
            seen_trough <= 1'b1;
         end else if (error_next) begin
            seen_trough <= 1'b0;
         end
      end
   end

   sat_counter #(.WIDTH(CNT_W)) u_period_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (trough_next || error_next),
      .inc   (ena && is_tracking(state)),
      .count (period_cnt)
   );

   sat_counter #(.WIDTH(CNT_W)) u_err_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (1'b0),
      .inc   (error_next),
      .count (err_count)
   );

endmodule
